// File: rtl/seg_pkg.sv
// Shared constants and types for the 7-segment scan driver.
// Segment data is active-low throughout: a 0 bit lights its segment.
package seg_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int SEG_W      = 7;
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef logic [SEG_W-1:0]           digit_seg_t;
    typedef digit_seg_t [NUM_DIGITS-1:0] segs_t;

    localparam digit_seg_t              SEG_BLANK = '1;
    localparam logic [NUM_DIGITS-1:0]   AN_OFF    = '1;

    // Active-low one-hot anode pattern for a digit index.
    function automatic logic [NUM_DIGITS-1:0] an_select(input logic [IDX_W-1:0] idx);
        logic [NUM_DIGITS-1:0] sel;
        sel      = AN_OFF;
        sel[idx] = 1'b0;
        return sel;
    endfunction

endpackage

// File: rtl/seg_scanner_scan_timer.sv
// Slot/digit/PWM timing for the display scanner. Produces the digit index,
// the blank/on phase, the PWM count within the on window and the frame pulse.
module scan_timer
    import seg_pkg::*;
#(
    parameter int SCAN_DIV     = 100_000,
    parameter int BLANK_CYCLES = 1_000
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    output logic [IDX_W-1:0] idx,
    output logic [3:0]       pwm,
    output logic             on,
    output logic             frame_start,
    output logic             frame_done
);

    localparam int                SLOT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [SLOT_W-1:0] slot_cnt;
    logic              slot_wrap;
    logic              frame_wrap;

    assign slot_wrap   = (slot_cnt == SLOT_LAST);
    assign frame_wrap  = slot_wrap && (idx == IDX_LAST);
    assign frame_start = (slot_cnt == '0) && (idx == '0);

    generate
        if (BLANK_CYCLES == 0) begin : g_noblank
            assign on = 1'b1;
        end else begin : g_blank
            assign on = (slot_cnt >= SLOT_W'(BLANK_CYCLES));
        end
    endgenerate

    // pwm stays 0 through blanking and on the first on cycle, so it counts the
    // on-window position; it restarts at every slot boundary.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slot_cnt   <= '0;
            idx        <= '0;
            pwm        <= '0;
            frame_done <= 1'b0;
        end else if (!enable) begin
            slot_cnt   <= '0;
            idx        <= '0;
            pwm        <= '0;
            frame_done <= 1'b0;
        end else begin
            slot_cnt   <= slot_wrap ? '0 : slot_cnt + 1'b1;
            if (slot_wrap)
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            pwm        <= (on && !slot_wrap) ? pwm + 1'b1 : 4'd0;
            frame_done <= frame_wrap;
        end
    end

endmodule

// File: rtl/seg_scanner.sv
// Time-multiplexed 7-segment driver: frame snapshot against tearing, dead-time
// blanking against ghosting, and 16-level PWM brightness.
module seg_scanner
    import seg_pkg::*;
#(
    parameter int SCAN_DIV     = 100_000,
    parameter int BLANK_CYCLES = 1_000
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic [NUM_DIGITS-1:0][SEG_W-1:0] segs_in,
    input  logic [NUM_DIGITS-1:0]            dp_in,
    input  logic                             enable,
    input  logic [3:0]                       brightness,
    output logic [NUM_DIGITS-1:0]            an,
    output logic [SEG_W-1:0]                 seg_out,
    output logic                             dp_out,
    output logic                             frame_done
);

    logic [IDX_W-1:0]      idx;
    logic [3:0]            pwm;
    logic                  on;
    logic                  frame_start;

    segs_t                 shadow_segs;
    logic [NUM_DIGITS-1:0] shadow_dp;
    logic [3:0]            shadow_bright;

    logic                  snap;
    segs_t                 cur_segs;
    logic [NUM_DIGITS-1:0] cur_dp;
    logic [3:0]            cur_bright;
    logic                  lit;

    scan_timer #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk         (clk),
        .resetn      (resetn),
        .enable      (enable),
        .idx         (idx),
        .pwm         (pwm),
        .on          (on),
        .frame_start (frame_start),
        .frame_done  (frame_done)
    );

    // With zero dead-time the snapshot cycle is itself lit, so it must
    // display the values being captured rather than the previous frame's.
    assign snap       = enable && frame_start;
    assign cur_segs   = snap ? segs_t'(segs_in) : shadow_segs;
    assign cur_dp     = snap ? dp_in      : shadow_dp;
    assign cur_bright = snap ? brightness : shadow_bright;
    assign lit        = enable && on && (pwm <= cur_bright);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shadow_segs   <= {NUM_DIGITS{SEG_BLANK}};
            shadow_dp     <= '1;
            shadow_bright <= 4'hF;
        end else if (snap) begin
            shadow_segs   <= segs_in;
            shadow_dp     <= dp_in;
            shadow_bright <= brightness;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            an      <= AN_OFF;
            seg_out <= SEG_BLANK;
            dp_out  <= 1'b1;
        end else if (lit) begin
            an      <= an_select(idx);
            seg_out <= cur_segs[idx];
            dp_out  <= cur_dp[idx];
        end else begin
            an      <= AN_OFF;
            seg_out <= SEG_BLANK;
            dp_out  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seg_scanner.sv
// Randomized bench for seg_scanner: two instances (normal and zero dead-time)
// checked every cycle against a frame-position reference model.
module tb_seg_scanner;

    logic            clk = 1'b0;
    logic            resetn = 1'b1;
    logic            enable = 1'b0;
    logic [7:0][6:0] segs_in = '1;
    logic [7:0]      dp_in = '1;
    logic [3:0]      brightness = 4'hF;

    logic [7:0] an_a, an_b;
    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b, fd_a, fd_b;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seg_scanner #(.SCAN_DIV(8), .BLANK_CYCLES(2)) dut_a (
        .clk(clk), .resetn(resetn), .segs_in(segs_in), .dp_in(dp_in),
        .enable(enable), .brightness(brightness),
        .an(an_a), .seg_out(seg_a), .dp_out(dp_a), .frame_done(fd_a)
    );

    seg_scanner #(.SCAN_DIV(2), .BLANK_CYCLES(0)) dut_b (
        .clk(clk), .resetn(resetn), .segs_in(segs_in), .dp_in(dp_in),
        .enable(enable), .brightness(brightness),
        .an(an_b), .seg_out(seg_b), .dp_out(dp_b), .frame_done(fd_b)
    );

    // Reference model: t counts enabled cycles since reset/re-enable; the
    // frame position, digit and slot offset follow by plain arithmetic.
    int              sd[2] = '{8, 2};
    int              bl[2] = '{2, 0};
    int              t[2];
    logic [7:0][6:0] m_segs[2];
    logic [7:0]      m_dp[2];
    int              m_br[2];
    logic [7:0]      x_an[2];
    logic [6:0]      x_seg[2];
    logic            x_dp[2];
    logic            x_fd[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int f, p, d, s;
            x_an[i] = 8'hFF; x_seg[i] = 7'h7F; x_dp[i] = 1'b1; x_fd[i] = 1'b0;
            if (!resetn) begin
                t[i] = 0; m_segs[i] = '1; m_dp[i] = '1; m_br[i] = 15;
            end else if (!enable) begin
                t[i] = 0;
            end else begin
                f = sd[i] * 8;
                p = t[i] % f;
                if (p == 0) begin
                    m_segs[i] = segs_in; m_dp[i] = dp_in; m_br[i] = int'(brightness);
                end
                d = p / sd[i];
                s = p % sd[i];
                if (s >= bl[i] && ((s - bl[i]) % 16) <= m_br[i]) begin
                    x_an[i]  = ~(8'd1 << d);
                    x_seg[i] = m_segs[i][d];
                    x_dp[i]  = m_dp[i][d];
                end
                x_fd[i] = (p == f - 1);
                t[i]++;
            end
        end
    endtask

    task automatic check_outs();
        chk("an_a",  an_a,  x_an[0]);
        chk("seg_a", seg_a, x_seg[0]);
        chk("dp_a",  dp_a,  x_dp[0]);
        chk("fd_a",  fd_a,  x_fd[0]);
        chk("an_b",  an_b,  x_an[1]);
        chk("seg_b", seg_b, x_seg[1]);
        chk("dp_b",  dp_b,  x_dp[1]);
        chk("fd_b",  fd_b,  x_fd[1]);
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        check_outs();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        #1 resetn = 1'b0;
        ticks(3);
        resetn = 1'b1;

        // Scan order with a recognisable pattern.
        for (int k = 0; k < 8; k++) segs_in[k] = 7'h40 | 7'(k);
        dp_in = 8'hFE; brightness = 4'd15; enable = 1'b1;
        ticks(128);

        // Mid-frame change during digit 2 must wait for the next frame.
        for (int k = 0; k < 100 && ((t[0] % 64) / 8) != 2; k++) tick();
        segs_in[5] = 7'h00;
        brightness = 4'd3;
        ticks(128);
        brightness = 4'd0;
        ticks(128);
        brightness = 4'd15;
        ticks(64);

        // Drop enable during digit 3, then resume with new data.
        for (int k = 0; k < 100 && ((t[0] % 64) / 8) != 3; k++) tick();
        enable = 1'b0;
        ticks(3);
        for (int k = 0; k < 8; k++) segs_in[k] = 7'($urandom);
        dp_in = 8'($urandom);
        enable = 1'b1;
        ticks(80);

        // Asynchronous reset while digit 2 is lit must blank before the next edge.
        for (int k = 0; k < 200 && x_an[0] !== 8'hFB; k++) tick();
        chk("reach_an_fb", an_a, 8'hFB);
        #2 resetn = 1'b0;
        #1;
        chk("async_an_a", an_a, 8'hFF);
        chk("async_seg_a", seg_a, 7'h7F);
        chk("async_dp_a", dp_a, 1'b1);
        chk("async_an_b", an_b, 8'hFF);
        ticks(3);
        resetn = 1'b1;

        // Random traffic: data/brightness changes and enable toggles.
        for (int k = 0; k < 2500; k++) begin
            if ($urandom_range(0, 99) < 4) begin
                for (int j = 0; j < 8; j++) segs_in[j] = 7'($urandom);
                dp_in = 8'($urandom);
            end
            if ($urandom_range(0, 99) < 3) brightness = 4'($urandom);
            if (enable && $urandom_range(0, 99) < 1) enable = 1'b0;
            else if (!enable && $urandom_range(0, 99) < 30) enable = 1'b1;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
